// File: rtl/alu_arb_pkg.sv
// ALU encodings and operand record shared by the ALU, the arbiter wrapper and its bench.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_arb_pkg;

    localparam int XLEN = 32;

    // funct3 field of the 4-bit control word {funct3, funct7_5}
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Full control words as seen on req_ctrl
    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b0001;
    localparam logic [3:0] CTRL_SLL  = 4'b0010;
    localparam logic [3:0] CTRL_SLT  = 4'b0100;
    localparam logic [3:0] CTRL_SLTU = 4'b0110;
    localparam logic [3:0] CTRL_XOR  = 4'b1000;
    localparam logic [3:0] CTRL_SRL  = 4'b1010;
    localparam logic [3:0] CTRL_SRA  = 4'b1011;
    localparam logic [3:0] CTRL_OR   = 4'b1100;
    localparam logic [3:0] CTRL_AND  = 4'b1110;

    // Operand register layout: operands, control word and the requester that owns the op
    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [3:0]      ctrl;
        logic            owner;
    } op_rec_t;

    // funct3 portion of a control word
    function automatic logic [2:0] ctrl_funct3(input logic [3:0] ctrl);
        return ctrl[3:1];
    endfunction

    // funct7 bit 5 selects SUB over ADD and SRA over SRL
    function automatic logic ctrl_alt(input logic [3:0] ctrl);
        return ctrl[0];
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU with zero and sign flags.
// Latency: purely combinational, no state.
// Backpressure: none; outputs follow inputs.
module alu
    import alu_arb_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      ctrl_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            sign_o
);

    logic [4:0]             shamt;
    logic signed [XLEN-1:0] sra_res;
    logic [XLEN-1:0]        res;

    assign shamt = b_i[4:0];

    // Arithmetic shift kept in its own signed signal so the mux below cannot strip its signedness
    always_comb begin
        sra_res = $signed(a_i) >>> shamt;
    end

    // Operation select on funct3, funct7_5 picks the alternate form of add and right shift
    always_comb begin
        res = '0;
        case (ctrl_funct3(ctrl_i))
            F3_ADD_SUB: res = ctrl_alt(ctrl_i) ? (a_i - b_i) : (a_i + b_i);
            F3_SLL:     res = a_i << shamt;
            F3_SLT:     res = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            F3_SLTU:    res = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            F3_XOR:     res = a_i ^ b_i;
            F3_SRL_SRA: res = ctrl_alt(ctrl_i) ? sra_res : (a_i >> shamt);
            F3_OR:      res = a_i | b_i;
            F3_AND:     res = a_i & b_i;
            default:    res = '0;
        endcase
    end

    assign result_o = res;
    assign zero_o   = (res == '0);
    assign sign_o   = res[XLEN-1];

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from two eligibility bits.
// Latency: grant is combinational; the last-winner pointer updates on the grant edge.
// Backpressure: a requester that is not eligible is never granted; ties go to the one not granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig_i,
    output logic [1:0] gnt_o
);

    // Index of the requester granted most recently; reset to 1 so requester 0 wins the first tie
    logic last_q, last_d;
    logic [1:0] gnt;

    // Single eligible requester wins outright; a tie goes to the one not granted last
    always_comb begin
        gnt = 2'b00;
        case (elig_i)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer only moves when a grant is actually issued
    always_comb begin
        last_d = last_q;
        if (gnt != 2'b00) begin
            last_d = gnt[1];
        end
    end

    // Last-winner pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt_o = gnt;

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two valid/ready requesters with round-robin arbitration.
// Latency: accept at edge k, result registered and rsp_valid high after edge k+1.
// Backpressure: one op outstanding per requester; a held result blocks that requester's next grant.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [63:0]      req_op1,
    input  logic [63:0]      req_op2,
    input  logic [7:0]       req_ctrl,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [63:0]      rsp_result,
    output logic [1:0]       rsp_zero,
    output logic [1:0]       rsp_sign,
    output logic [CNT_W-1:0] op_count
);

    op_rec_t               op_q, op_d;
    logic                  op_vld_q, op_vld_d;
    logic [1:0]            inflight;
    logic [1:0]            elig;
    logic [1:0]            gnt;

    logic [1:0]            rsp_vld_q, rsp_vld_d;
    logic [1:0][XLEN-1:0]  rsp_res_q, rsp_res_d;
    logic [1:0]            rsp_zero_q, rsp_zero_d;
    logic [1:0]            rsp_sign_q, rsp_sign_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [XLEN-1:0]       alu_res;
    logic                  alu_zero;
    logic                  alu_sign;

    // A requester whose op is in the operand register or whose result is still held cannot issue again
    assign inflight = op_vld_q ? (op_q.owner ? 2'b10 : 2'b01) : 2'b00;
    assign elig     = req_valid & ~rsp_vld_q & ~inflight;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .elig_i (elig),
        .gnt_o  (gnt)
    );

    // Grant is already qualified by req_valid, so it doubles as the handshake
    assign req_ready = gnt;

    // Capture the granted requester's operands; the slot empties when nothing new is granted
    always_comb begin
        op_d     = op_q;
        op_vld_d = 1'b0;
        if (gnt != 2'b00) begin
            op_vld_d   = 1'b1;
            op_d.owner = gnt[1];
            op_d.op1   = gnt[1] ? req_op1[63:32] : req_op1[31:0];
            op_d.op2   = gnt[1] ? req_op2[63:32] : req_op2[31:0];
            op_d.ctrl  = gnt[1] ? req_ctrl[7:4]  : req_ctrl[3:0];
        end
    end

    // The shared ALU sees only the registered operands
    alu u_alu (
        .a_i      (op_q.op1),
        .b_i      (op_q.op2),
        .ctrl_i   (op_q.ctrl),
        .result_o (alu_res),
        .zero_o   (alu_zero),
        .sign_o   (alu_sign)
    );

    // Consumed results release their valid; the executing op lands in its owner's buffer
    always_comb begin
        rsp_vld_d  = rsp_vld_q & ~rsp_ready;
        rsp_res_d  = rsp_res_q;
        rsp_zero_d = rsp_zero_q;
        rsp_sign_d = rsp_sign_q;
        cnt_d      = cnt_q;
        if (op_vld_q) begin
            // The owner's buffer is empty here: it was not eligible while its result was held
            rsp_vld_d[op_q.owner]  = 1'b1;
            rsp_res_d[op_q.owner]  = alu_res;
            rsp_zero_d[op_q.owner] = alu_zero;
            rsp_sign_d[op_q.owner] = alu_sign;
            cnt_d                  = cnt_q + 1'b1;
        end
    end

    // Operand register; reset discards any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            op_vld_q <= 1'b0;
        end else begin
            op_q     <= op_d;
            op_vld_q <= op_vld_d;
        end
    end

    // Per-requester result buffers and completed-op counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q  <= '0;
            rsp_res_q  <= '0;
            rsp_zero_q <= '0;
            rsp_sign_q <= '0;
            cnt_q      <= '0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_res_q  <= rsp_res_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_sign_q <= rsp_sign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rsp_valid  = rsp_vld_q;
    assign rsp_result = rsp_res_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_sign   = rsp_sign_q;
    assign op_count   = cnt_q;

endmodule
